// File: rtl/gain_gpio_writer_if.sv
// Control/status and GPIO bus between a gain-set requester, the writer and the gain-trim receiver.
// The master side requests a new gain set and returns readback. The slave side is the writer.
interface gain_gpio_writer_if #(
    parameter int unsigned GPIO_WIDTH = 32,
    parameter int unsigned NUM_GAINS  = 4,
    parameter int unsigned GAIN_WIDTH = 27
);
    localparam int unsigned IDX_W = (NUM_GAINS > 1) ? $clog2(NUM_GAINS) : 1;

    logic                             start;
    logic [NUM_GAINS*GAIN_WIDTH-1:0]  gains;
    logic                             busy;
    logic                             done;
    logic                             error;
    logic [IDX_W-1:0]                 errIndex;
    logic [GPIO_WIDTH-1:0]            gpioData;
    logic [NUM_GAINS-1:0]             gainStrobes;
    logic [GPIO_WIDTH*NUM_GAINS-1:0]  gainRBK;

    modport master (
        output start, gains, gainRBK,
        input  busy, done, error, errIndex, gpioData, gainStrobes
    );

    modport slave (
        input  start, gains, gainRBK,
        output busy, done, error, errIndex, gpioData, gainStrobes
    );
endinterface

// File: rtl/gain_gpio_writer.sv
// Writes a shadowed gain set to a GPIO gain-trim receiver one strobed word at a time,
// waits for the set to settle, then verifies the receiver's readback against the shadow.
module gain_gpio_writer #(
    parameter int unsigned GPIO_WIDTH = 32,
    parameter int unsigned NUM_GAINS  = 4,
    parameter int unsigned GAIN_WIDTH = 27,
    parameter int unsigned SETTLE     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    gain_gpio_writer_if.slave   bus_io
);
    localparam int unsigned IDX_W = (NUM_GAINS > 1) ? $clog2(NUM_GAINS) : 1;
    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned SET_W = NUM_GAINS * GAIN_WIDTH;

    if (NUM_GAINS < 2 || GAIN_WIDTH > GPIO_WIDTH || SETTLE < 1) begin : g_bad_params
        $error("gain_gpio_writer: illegal parameter combination");
    end

    typedef enum logic [2:0] {IDLE, WRITE, SETTLING, VERIFY, DONE} state_e;

    state_e                 state_q, state_d;
    logic [SET_W-1:0]       shadow_q, shadow_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   phase_q, phase_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_GAINS-1:0]   strobes_q, strobes_d;
    logic [GPIO_WIDTH-1:0]  gpio_q, gpio_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
    logic [IDX_W-1:0]       err_idx_q, err_idx_d;

    logic [IDX_W-1:0]       idx_nxt;
    logic [GAIN_WIDTH-1:0]  next_gain;
    logic [NUM_GAINS-1:0]   mismatch;
    logic [IDX_W-1:0]       first_bad;

    assign idx_nxt = idx_q + IDX_W'(1);

    // Shadow word for the next write slot.
    always_comb begin
        next_gain = '0;
        for (int unsigned i = 0; i < NUM_GAINS; i++) begin
            if (idx_nxt == IDX_W'(i)) next_gain = shadow_q[i*GAIN_WIDTH +: GAIN_WIDTH];
        end
    end

    // Full-word readback compare; any set bit above the gain width is a mismatch.
    always_comb begin
        mismatch  = '0;
        first_bad = '0;
        for (int unsigned i = 0; i < NUM_GAINS; i++) begin
            mismatch[i] = bus_io.gainRBK[i*GPIO_WIDTH +: GPIO_WIDTH]
                          != GPIO_WIDTH'(shadow_q[i*GAIN_WIDTH +: GAIN_WIDTH]);
        end
        for (int i = int'(NUM_GAINS) - 1; i >= 0; i--) begin
            if (mismatch[i]) first_bad = IDX_W'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        idx_d     = idx_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        strobes_d = '0;
        gpio_d    = gpio_q;
        done_d    = 1'b0;
        error_d   = error_q;
        err_idx_d = err_idx_q;
        unique case (state_q)
            IDLE: begin
                if (bus_io.start) begin
                    state_d   = WRITE;
                    shadow_d  = bus_io.gains;
                    idx_d     = '0;
                    phase_d   = 1'b0;
                    strobes_d = NUM_GAINS'(1);
                    gpio_d    = GPIO_WIDTH'(bus_io.gains[GAIN_WIDTH-1:0]);
                    error_d   = 1'b0;
                    err_idx_d = '0;
                end
            end
            WRITE: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else if (idx_q == IDX_W'(NUM_GAINS - 1)) begin
                    state_d = SETTLING;
                    cnt_d   = '0;
                end else begin
                    idx_d     = idx_nxt;
                    phase_d   = 1'b0;
                    strobes_d = NUM_GAINS'(1) << idx_nxt;
                    gpio_d    = GPIO_WIDTH'(next_gain);
                end
            end
            SETTLING: begin
                if (cnt_q == CNT_W'(SETTLE - 1)) state_d = VERIFY;
                else                             cnt_d   = cnt_q + CNT_W'(1);
            end
            VERIFY: begin
                state_d   = DONE;
                done_d    = 1'b1;
                error_d   = |mismatch;
                err_idx_d = first_bad;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == WRITE) || (state_d == SETTLING) || (state_d == VERIFY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shadow_q  <= '0;
            idx_q     <= '0;
            phase_q   <= 1'b0;
            cnt_q     <= '0;
            strobes_q <= '0;
            gpio_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            err_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            idx_q     <= idx_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            strobes_q <= strobes_d;
            gpio_q    <= gpio_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            err_idx_q <= err_idx_d;
        end
    end

    assign bus_io.busy        = busy_q;
    assign bus_io.done        = done_q;
    assign bus_io.error       = error_q;
    assign bus_io.errIndex    = err_idx_q;
    assign bus_io.gpioData    = gpio_q;
    assign bus_io.gainStrobes = strobes_q;
endmodule

// File: tb/tb_gain_gpio_writer.sv
// Bench for gain_gpio_writer: echoing receiver model with fault injection, write/result scoreboard,
// a vector table of gain sets, and hand sequences for restart, mid-run reset and back-to-back runs.
module tb_gain_gpio_writer;
    localparam int unsigned GPIO_W   = 32;
    localparam int unsigned NG       = 4;
    localparam int unsigned GW       = 27;
    localparam int unsigned ST       = 2;
    localparam int unsigned DONE_OFS = 2*NG + ST + 2;
    localparam int unsigned NV       = 7;

    localparam logic [NG*GW-1:0] G0   = {27'h4000000, 27'h3000000, 27'h2000000, 27'h1000000};
    localparam logic [NG*GW-1:0] GALT = {27'h0111111, 27'h0222222, 27'h0333333, 27'h0444444};

    typedef struct {
        logic [NG*GW-1:0] gains;
        logic [2:0]       fault;
        logic             exp_err;
        logic [1:0]       exp_idx;
    } vec_t;
    typedef struct { int idx; logic [GPIO_W-1:0] data; } wr_t;
    typedef struct { logic err; logic [1:0] idx; } res_t;

    logic clk = 1'b0;
    logic rst_n;
    gain_gpio_writer_if #(.GPIO_WIDTH(GPIO_W), .NUM_GAINS(NG), .GAIN_WIDTH(GW)) bus ();

    gain_gpio_writer #(.GPIO_WIDTH(GPIO_W), .NUM_GAINS(NG), .GAIN_WIDTH(GW), .SETTLE(ST)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    wr_t              wr_q[$];
    res_t             res_q[$];
    vec_t             vecs[NV];
    logic [GPIO_W-1:0] rbk[NG];
    logic [2:0]       fault;
    int               cyc = 0;
    int               e0 = 0;
    int               n_checks = 0;
    int               n_pass = 0;
    wr_t              mw;
    res_t             mr;

    assign bus.gainRBK = {rbk[3], rbk[2], rbk[1], rbk[0]};

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Receiver: echoes each strobed word, with optional corruption per fault bit.
    function automatic logic [GPIO_W-1:0] recv(input int i, input logic [GPIO_W-1:0] d,
                                               input logic [2:0] f);
        logic [GPIO_W-1:0] r;
        r = d;
        if (f[0] && i == 2) r = 32'h01FF_FFFF;
        if (f[1] && i == 1) r = r | 32'h8000_0000;
        if (f[2] && i == 3) r = r ^ 32'h0000_0001;
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.gainStrobes != '0) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_strobe", 64'(bus.gainStrobes), 64'(0));
                end else begin
                    mw = wr_q.pop_front();
                    chk("strobe",       64'(bus.gainStrobes), 64'(1) << mw.idx);
                    chk("write_data",   64'(bus.gpioData), 64'(mw.data));
                    chk("strobe_cycle", 64'(cyc - e0), 64'(1 + 2*mw.idx));
                    chk("busy_write",   64'(bus.busy), 64'(1));
                end
                for (int i = 0; i < int'(NG); i++)
                    if (bus.gainStrobes[i]) rbk[i] = recv(i, bus.gpioData, fault);
            end
            if (bus.done === 1'b1) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_done", 64'(1), 64'(0));
                end else begin
                    mr = res_q.pop_front();
                    chk("error",        64'(bus.error), 64'(mr.err));
                    chk("errIndex",     64'(bus.errIndex), 64'(mr.idx));
                    chk("done_cycle",   64'(cyc - e0), 64'(DONE_OFS));
                    chk("busy_at_done", 64'(bus.busy), 64'(0));
                end
            end
        end
    end

    // Called at a negedge; start is high for exactly that cycle.
    task automatic launch(input logic [NG*GW-1:0] g, input logic [2:0] f,
                          input logic ee, input logic [1:0] ei);
        bus.gains = g;
        fault     = f;
        for (int i = 0; i < int'(NG); i++)
            wr_q.push_back('{idx: i, data: GPIO_W'(g[i*GW +: GW])});
        res_q.push_back('{err: ee, idx: ei});
        bus.start = 1'b1;
        e0        = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("done_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.gains = '0;
        fault     = '0;
        for (int i = 0; i < int'(NG); i++) rbk[i] = '0;

        vecs[0] = '{gains: G0, fault: 3'd0, exp_err: 1'b0, exp_idx: 2'd0};
        vecs[1] = '{gains: G0, fault: 3'd1, exp_err: 1'b1, exp_idx: 2'd2};
        vecs[2] = '{gains: G0, fault: 3'd2, exp_err: 1'b1, exp_idx: 2'd1};
        vecs[3] = '{gains: {27'h7FFFFFF, 27'h0000001, 27'h0ABCDEF, 27'h5555555},
                    fault: 3'd3, exp_err: 1'b1, exp_idx: 2'd1};
        vecs[4] = '{gains: '0, fault: 3'd4, exp_err: 1'b1, exp_idx: 2'd3};
        vecs[5] = '{gains: {27'h1234567, 27'h7654321, 27'h0000000, 27'h7FFFFFF},
                    fault: 3'd0, exp_err: 1'b0, exp_idx: 2'd0};
        vecs[6] = '{gains: {27'h1234567, 27'h7654321, 27'h0000000, 27'h7FFFFFF},
                    fault: 3'd5, exp_err: 1'b1, exp_idx: 2'd2};

        repeat (3) @(negedge clk);
        chk("rst_busy",     64'(bus.busy), 64'(0));
        chk("rst_done",     64'(bus.done), 64'(0));
        chk("rst_error",    64'(bus.error), 64'(0));
        chk("rst_errIndex", 64'(bus.errIndex), 64'(0));
        chk("rst_gpioData", 64'(bus.gpioData), 64'(0));
        chk("rst_strobes",  64'(bus.gainStrobes), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < int'(NV); v++) begin
            launch(vecs[v].gains, vecs[v].fault, vecs[v].exp_err, vecs[v].exp_idx);
            wait_done(40);
            @(negedge clk);
            chk("wr_q_empty",  64'(wr_q.size()), 64'(0));
            chk("res_q_empty", 64'(res_q.size()), 64'(0));
        end

        // Start and gain changes while busy must not disturb the running set.
        @(negedge clk);
        launch(G0, 3'd0, 1'b0, 2'd0);
        repeat (2) @(negedge clk);
        bus.gains = GALT;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(40);
        repeat (16) @(negedge clk);
        chk("restart_wr_q", 64'(wr_q.size()), 64'(0));

        // Mid-sequence reset: strobe must drop without a clock edge.
        launch(G0, 3'd0, 1'b0, 2'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_strobe", 64'(bus.gainStrobes), 64'(4'b0100));
        chk("pre_rst_data",   64'(bus.gpioData), 64'(GPIO_W'(G0[2*GW +: GW])));
        rst_n = 1'b0;
        #1;
        chk("async_strobe_drop", 64'(bus.gainStrobes), 64'(0));
        chk("async_busy",        64'(bus.busy), 64'(0));
        @(negedge clk);
        chk("rst_pending_writes", 64'(wr_q.size()), 64'(2));
        wr_q.delete();
        res_q.delete();
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_busy", 64'(bus.busy), 64'(0));

        // Error run, then a new start in the cycle right after DONE.
        launch(G0, 3'd1, 1'b1, 2'd2);
        wait_done(40);
        chk("err_before_restart", 64'(bus.error), 64'(1));
        @(negedge clk);
        launch(G0, 3'd0, 1'b0, 2'd0);
        chk("error_cleared",    64'(bus.error), 64'(0));
        chk("errIndex_cleared", 64'(bus.errIndex), 64'(0));
        chk("busy_after_start", 64'(bus.busy), 64'(1));
        wait_done(40);

        repeat (20) @(negedge clk);
        chk("final_wr_q",  64'(wr_q.size()), 64'(0));
        chk("final_res_q", 64'(res_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/gain_gpio_writer.md
GAIN_GPIO_WRITER -- requirements
Module: gain_gpio_writer

Interface
REQ-001 SHALL have parameter GPIO_WIDTH, default 32, processor GPIO word width.
REQ-002 SHALL have parameter NUM_GAINS, default 4, number of per-channel gains.
REQ-003 SHALL have parameter GAIN_WIDTH, default 27, unsigned gain width; 0x4000000 is unity.
REQ-004 SHALL have parameter SETTLE, default 2, cycles waited between commit and readback compare (minimum 1).
REQ-005 SHALL have port clk  input  1  sole clock.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  input  1  one-cycle request to load a new gain set.
REQ-008 SHALL have port gains  input  NUM_GAINS*GAIN_WIDTH  gain set, gain i at bits [i*GAIN_WIDTH +: GAIN_WIDTH].
REQ-009 SHALL have port busy  output  1  sequence in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at sequence end.
REQ-011 SHALL have port error  output  1  sticky readback-mismatch flag.
REQ-012 SHALL have port errIndex  output  clog2(NUM_GAINS)  lowest mismatching gain index.
REQ-013 SHALL have port gpioData  output  GPIO_WIDTH  write data toward the gain-trim receiver.
REQ-014 SHALL have port gainStrobes  output  NUM_GAINS  one-hot write strobes toward the receiver.
REQ-015 SHALL have port gainRBK  input  GPIO_WIDTH*NUM_GAINS  applied-gain readback from the receiver.

Function
REQ-016 SHALL fail elaboration if NUM_GAINS < 2 or GAIN_WIDTH > GPIO_WIDTH.
REQ-017 SHALL implement states IDLE, WRITE, SETTLE, VERIFY, DONE; reset state IDLE.
REQ-018 SHALL, in IDLE with start=1 on edge E0, latch gains into a shadow register and enter WRITE for cycles E0+1 .. E0+2*NUM_GAINS.
REQ-019 SHALL give each gain index i (0 .. NUM_GAINS-1, ascending) a 2-cycle WRITE slot: cycle 0 drives gpioData = zero-extended shadow gain i with gainStrobes = (1<<i); cycle 1 holds gpioData with gainStrobes = 0.
REQ-020 SHALL write index NUM_GAINS-1 last, so that its strobe commits the whole set in the receiver.
REQ-021 SHALL never assert more than one gainStrobes bit in a cycle, and never assert any bit outside WRITE slot cycle 0.
REQ-022 SHALL remain in SETTLE for exactly SETTLE cycles, gpioData held at last value.
REQ-023 SHALL, in VERIFY (one cycle), compare every gainRBK word i against the zero-extended shadow gain i, including upper GPIO_WIDTH-GAIN_WIDTH bits, which must be zero.
REQ-024 SHALL, on any mismatch, set error=1 and errIndex = lowest mismatching i; on full match, leave error=0 and errIndex=0.
REQ-025 SHALL enter DONE for one cycle with done=1, then return to IDLE.
REQ-026 SHALL assert busy in WRITE, SETTLE and VERIFY; busy=0 in IDLE and DONE.
REQ-027 SHALL give, for defaults, strobes at E0+1,3,5,7, VERIFY at E0+11, done at E0+12.
REQ-028 SHALL ignore start while busy=1 or in DONE; shadow SHALL NOT change mid-sequence when gains changes.
REQ-029 SHALL clear error and errIndex on an accepted start.
REQ-030 SHALL accept a start in the cycle after DONE, i.e. back-to-back sequences.

Reset
REQ-031 SHALL, on rst_n=0, asynchronously force IDLE, busy=0, done=0, error=0, errIndex=0, gpioData=0, gainStrobes=0, shadow=0.
REQ-032 SHALL, on reset mid-sequence, drop any active strobe immediately and issue no further writes after release until a new start.

Verification
REQ-033 SHALL cover: defaults, gains={0x4000000,0x3000000,0x2000000,0x1000000}, receiver model echoing writes -> strobes 0001,0010,0100,1000 at E0+1,3,5,7 with matching gpioData; done at E0+12; error=0.
REQ-034 SHALL cover: receiver model forcing gainRBK word 2 to 0x1FFFFFF -> error=1, errIndex=2 at done.
REQ-035 SHALL cover: gainRBK word 1 bit 31 set, low bits correct -> error=1, errIndex=1.
REQ-036 SHALL cover: start pulsed at E0+4 and gains changed at E0+3 -> no restart, written values equal original set.
REQ-037 SHALL cover: rst_n low at E0+5 for 1 cycle -> gainStrobes=0 asynchronously, busy=0, no strobe after release.
REQ-038 SHALL cover: start at DONE+1 after an error run with matching model -> error cleared at E0+1, second done with error=0.
